// File: rtl/vga_timing_recovery.sv
// vga_timing_recovery: recovers pixel/line position and lock status from
// active-high hs/vs sync inputs sampled on the pixel clock.
// Optional feature macro: VGA_RX_ERRCNT_EN adds an 8-bit saturating
// err_count output that counts err pulses.
module vga_timing_recovery #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_START     = 144,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_START     = 35,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs,
    input  logic       vs,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       active,
    output logic       locked,
    output logic       err,
    output logic [9:0] h_period,
    output logic [9:0] v_period
`ifdef VGA_RX_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    localparam logic [9:0] CNT_MAX = '1;
    localparam logic [9:0] CNT_PRE = 10'd1022;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FIRST = 10'(H_START);
    localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_FIRST = 10'(V_START);
    localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE);
    localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

    logic       hs_q;
    logic       vs_rise_q;    // vs as sampled at the previous hs rise
    logic       seen_frame;   // at least one frame start since reset
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hs_rise;
    logic       frame_start;
    logic       line_err;
    logic       frame_err;
    logic       any_err;
    state_t     state_q, state_d;
    logic [2:0] good_q, good_d;

    // Edge detection and error classification for the current cycle.
    // Timeouts fire on the single edge where a counter steps 1022 -> 1023,
    // so a saturated counter produces exactly one error pulse.
    always_comb begin
        hs_rise     = hs & ~hs_q;
        frame_start = hs_rise & vs & ~vs_rise_q;
        line_err    = seen_frame & ((hs_rise & (h_cnt != H_LAST)) |
                                    (~hs_rise & (h_cnt == CNT_PRE)));
        frame_err   = seen_frame & ((frame_start & (v_cnt != V_LAST)) |
                                    (hs_rise & ~frame_start & (v_cnt == CNT_PRE)));
        any_err     = line_err | frame_err;
    end

    // Horizontal counter, line-period capture and sync history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q      <= 1'b0;
            vs_rise_q <= 1'b0;
            h_cnt     <= '0;
            h_period  <= '0;
        end else begin
            hs_q <= hs;
            if (hs_rise) begin
                h_cnt     <= '0;
                h_period  <= h_cnt + 10'd1;
                vs_rise_q <= vs;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Vertical counter, frame-period capture and registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_cnt      <= '0;
            v_period   <= '0;
            seen_frame <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= any_err;
            if (frame_start) begin
                v_cnt      <= '0;
                v_period   <= v_cnt + 10'd1;
                seen_frame <= 1'b1;
            end else if (hs_rise && (v_cnt != CNT_MAX)) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Lock FSM next state: acquire on a frame start, count clean frames, drop on any error.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (frame_start) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (any_err) begin
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                end else if (frame_start) begin
                    if (good_q == LOCK_N - 3'd1) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 3'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (any_err) begin
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                good_d  = '0;
            end
        endcase
    end

    // Recovered position outputs, decoded from the registered counters.
    always_comb begin
        locked = (state_q == ST_LOCKED);
        active = locked &&
                 (h_cnt >= H_FIRST) && (h_cnt < H_END) &&
                 (v_cnt >= V_FIRST) && (v_cnt < V_END);
        x      = active ? (h_cnt - H_FIRST) : '0;
        y      = active ? 9'(v_cnt - V_FIRST) : '0;
    end

`ifdef VGA_RX_ERRCNT_EN
    // Saturating count of error pulses; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Scoreboard bench for vga_timing_recovery using a reduced 100x20 raster so
// many frames fit in a short run. Stimulus pushes expected events into a queue
// keyed by clock edge; a negedge monitor pops and compares them.
module tb_vga_timing_recovery;

    localparam int unsigned HT  = 100;
    localparam int unsigned VT  = 20;
    localparam int unsigned HS0 = 20;
    localparam int unsigned HA  = 64;
    localparam int unsigned VS0 = 4;
    localparam int unsigned VA  = 12;
    localparam int unsigned LF  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs  = 1'b0;
    logic       vs  = 1'b0;
    logic [9:0] x;
    logic [8:0] y;
    logic       active;
    logic       locked;
    logic       err;
    logic [9:0] h_period;
    logic [9:0] v_period;
`ifdef VGA_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    vga_timing_recovery #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS0), .H_ACTIVE(HA),
        .V_START(VS0), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs),
        .x(x), .y(y), .active(active), .locked(locked), .err(err),
        .h_period(h_period), .v_period(v_period)
`ifdef VGA_RX_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // kind: 0 = hs rise, 1 = h timeout, 2 = pixel probe, 3 = reset state
    typedef struct {
        int unsigned edge_no;
        int          kind;
        logic        err;
        logic        locked;
        int unsigned hp;
        int unsigned vp;
        logic        act;
        int unsigned ex;
        int unsigned ey;
    } rec_t;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state (frame-level view of the stream)
    int unsigned m_prev_rise;   // edge at which the horizontal count was last zero
    int          m_st;          // 0 unlocked, 1 acquiring, 2 locked
    int          m_good;
    bit          m_seen;
    bit          m_vs_last;
    int unsigned m_vcount;      // line index within the current frame
    int unsigned m_vp;
    int          m_errs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_cnt, act, exp);
        end
    endtask

    function automatic rec_t mk(input int unsigned e, input int k);
        rec_t r;
        r.edge_no = e; r.kind = k; r.err = 1'b0; r.locked = 1'b0;
        r.hp = 0; r.vp = 0; r.act = 1'b0; r.ex = 0; r.ey = 0;
        return r;
    endfunction

    task automatic model_release();
        m_prev_rise = edge_cnt;
        m_st = 0; m_good = 0; m_seen = 0; m_vs_last = 0;
        m_vcount = 0; m_vp = 0; m_errs = 0;
    endtask

    // One line: hs rises at the next edge, line lasts len clocks.
    task automatic send_line(input int unsigned len, input logic v);
        int unsigned e, hcnt, vcnt, hw, tmp;
        int unsigned ks[5];
        logic fs, lerr, ferr, te;
        rec_t r;
        e    = edge_cnt + 1;
        hcnt = e - m_prev_rise - 1;
        if (hcnt > 1023) hcnt = 1023;
        vcnt = m_vcount;
        fs   = v && !m_vs_last;
        lerr = m_seen && (hcnt != HT - 1);
        ferr = m_seen && ((fs && vcnt != VT - 1) || (!fs && vcnt == 1022));
        if (fs) m_vp = (vcnt + 1) % 1024;
        if (m_st == 0) begin
            if (fs) begin m_st = 1; m_good = 0; end
        end else if (lerr || ferr) begin
            m_st = 0; m_good = 0;
        end else if (m_st == 1 && fs) begin
            m_good++;
            if (m_good == LF) begin m_st = 2; m_good = 0; end
        end
        if (lerr || ferr) m_errs++;
        m_vcount    = fs ? 0 : ((vcnt < 1023) ? vcnt + 1 : 1023);
        m_vs_last   = v;
        if (fs) m_seen = 1;
        m_prev_rise = e;

        r = mk(e, 0);
        r.err = lerr || ferr; r.locked = (m_st == 2);
        r.hp = (hcnt + 1) % 1024; r.vp = m_vp;
        sb.push_back(r);

        ks = '{HS0 - 1, HS0, HS0 + HA - 1, HS0 + HA, $urandom_range(len - 1, 1)};
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4 - i; j++)
                if (ks[j] > ks[j+1]) begin tmp = ks[j]; ks[j] = ks[j+1]; ks[j+1] = tmp; end
        for (int i = 0; i < 5; i++) begin
            if (ks[i] >= 1 && ks[i] < len && ks[i] < 1023) begin
                r = mk(e + ks[i], 2);
                r.act = (m_st == 2) && ks[i] >= HS0 && ks[i] < HS0 + HA &&
                        m_vcount >= VS0 && m_vcount < VS0 + VA;
                r.ex = r.act ? ks[i] - HS0 : 0;
                r.ey = r.act ? m_vcount - VS0 : 0;
                sb.push_back(r);
            end
        end

        if (len >= 1024) begin
            te = m_seen;
            if (te) begin
                m_errs++;
                if (m_st != 0) begin m_st = 0; m_good = 0; end
            end
            r = mk(e + 1023, 1);
            r.err = te; r.locked = (m_st == 2);
            sb.push_back(r);
        end

        hw = (len / 2 > 8) ? 8 : len / 2;
        hs = 1'b1; vs = v;
        repeat (hw) @(negedge clk);
        hs = 1'b0;
        repeat (len - hw) @(negedge clk);
    endtask

    task automatic send_frame(input int unsigned nlines, input int special, input int unsigned slen);
        for (int j = 0; j < int'(nlines); j++)
            send_line((j == special) ? slen : HT, j < 2);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; hs = 1'b0; vs = 1'b0;
        sb.delete();
        sb.push_back(mk(edge_cnt, 3));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_release();
    endtask

    // Monitor: pop every record due at this edge and compare; err checked each cycle.
    logic mon_exp_err;
    rec_t mon_r;
    always @(negedge clk) begin
        mon_exp_err = 1'b0;
        while (sb.size() != 0 && sb[0].edge_no <= edge_cnt) begin
            mon_r = sb.pop_front();
            if (mon_r.edge_no != edge_cnt) begin
                chk("sb_order", mon_r.edge_no, edge_cnt);
            end else begin
                case (mon_r.kind)
                    0: begin
                        mon_exp_err = mon_r.err;
                        chk("rise_locked", locked, mon_r.locked);
                        chk("h_period", h_period, mon_r.hp);
                        chk("v_period", v_period, mon_r.vp);
                    end
                    1: begin
                        mon_exp_err = mon_r.err;
                        chk("timeout_locked", locked, mon_r.locked);
                    end
                    2: begin
                        chk("active", active, mon_r.act);
                        chk("x", x, mon_r.ex);
                        chk("y", y, mon_r.ey);
                    end
                    default: begin
                        chk("rst_x", x, 0);
                        chk("rst_y", y, 0);
                        chk("rst_active", active, 0);
                        chk("rst_locked", locked, 0);
                        chk("rst_h_period", h_period, 0);
                        chk("rst_v_period", v_period, 0);
                    end
                endcase
            end
        end
        chk("err", err, mon_exp_err);
    end

    initial begin
        int unsigned nl, sl;
        int sp;
        @(posedge clk); #2;
        sb.push_back(mk(edge_cnt, 3));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_release();

        for (int i = 0; i < 3; i++) send_line(HT, 1'b0);
        for (int f = 0; f < 4; f++) send_frame(VT, -1, HT);

        send_frame(VT, 10, HT - 1);
        for (int f = 0; f < 3; f++) send_frame(VT, -1, HT);

        send_frame(VT, 7, 1100);
        for (int f = 0; f < 3; f++) send_frame(VT, -1, HT);

        send_frame(VT - 1, -1, HT);
        for (int f = 0; f < 3; f++) send_frame(VT, -1, HT);

        for (int j = 0; j < 8; j++) send_line(HT, j < 2);
        send_line(50, 1'b0);
        do_reset();
        for (int j = 0; j < 5; j++) send_line(HT, 1'b0);
        for (int f = 0; f < 4; f++) send_frame(VT, -1, HT);

        for (int f = 0; f < 6; f++) begin
            nl = ($urandom_range(7, 0) == 0) ? ($urandom_range(1, 0) ? VT + 1 : VT - 1) : VT;
            sp = ($urandom_range(3, 0) == 0) ? int'($urandom_range(VT - 2, 0)) : -1;
            case ($urandom_range(3, 0))
                0: sl = HT - 1;
                1: sl = HT + 1;
                2: sl = HT - 3;
                default: sl = 1030;
            endcase
            send_frame(nl, sp, sl);
        end

`ifdef VGA_RX_ERRCNT_EN
        for (int i = 0; i < 300; i++) send_line(50, 1'b0);
        send_frame(VT, -1, HT);
`endif
        send_line(HT, 1'b0);

        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
`ifdef VGA_RX_ERRCNT_EN
        chk("err_count", err_count, (m_errs > 255) ? 255 : m_errs);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
